// File: rtl/aes_decipher_block_if.sv
// ----------------------------------------------------------------------------
// aes_decipher_block_if: request/key/result bundle for aes_decipher_block. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface aes_decipher_block_if;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, round_key, block,
    input  round, new_block, ready
  );

  modport slave (
    input  next, keylen, round_key, block,
    output round, new_block, ready
  );
endinterface

`default_nettype wire

// File: rtl/aes_decipher_block.sv
// ----------------------------------------------------------------------------
// aes_decipher_block: iterative AES-128/256 inverse cipher, external round keys. Rev 1.0
// AES_DECIPHER_SBOX_PAR_EN: substitute all four state words in one SBOX cycle.
// ----------------------------------------------------------------------------
`default_nettype none

module aes_inv_sbox (
  input  logic [31:0] sboxw_i,
  output logic [31:0] new_sboxw_o
);
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign new_sboxw_o = {INV_SBOX[sboxw_i[31:24]], INV_SBOX[sboxw_i[23:16]],
                        INV_SBOX[sboxw_i[15:8]],  INV_SBOX[sboxw_i[7:0]]};
endmodule

module aes_decipher_block (
  input  logic                 clk,
  input  logic                 reset_n,
  aes_decipher_block_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_SBOX  = 3'd2;
  localparam logic [2:0] S_MAIN  = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // m selects which of b, 2b, 4b, 8b are summed (09/0b/0d/0e)
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^
           (m[1] ? x2 : 8'h00) ^ (m[0] ? b  : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return r;
  endfunction

  // byte index is 4*col+row; row r is rotated right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  logic [2:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [127:0] new_block_q, new_block_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   cnt_q, cnt_d;

  logic [3:0]   w_nr;
  logic [127:0] w_state_sub;
  logic         w_sbox_last;

  assign w_nr = keylen_q ? 4'd14 : 4'd10;

`ifdef AES_DECIPHER_SBOX_PAR_EN
  logic [31:0] w_sub_word [4];

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox_par
      aes_inv_sbox u_inv_sbox (
        .sboxw_i     (state_q[127-32*i -: 32]),
        .new_sboxw_o (w_sub_word[i])
      );
    end
  endgenerate

  assign w_state_sub = {w_sub_word[0], w_sub_word[1], w_sub_word[2], w_sub_word[3]};
  assign w_sbox_last = 1'b1;
`else
  logic [31:0] w_sbox_in, w_sbox_out;

  aes_inv_sbox u_inv_sbox (
    .sboxw_i     (w_sbox_in),
    .new_sboxw_o (w_sbox_out)
  );

  always_comb begin
    w_sbox_in   = state_q[127:96];
    w_state_sub = state_q;
    unique case (cnt_q)
      2'd0: begin w_sbox_in = state_q[127:96]; w_state_sub[127:96] = w_sbox_out; end
      2'd1: begin w_sbox_in = state_q[95:64];  w_state_sub[95:64]  = w_sbox_out; end
      2'd2: begin w_sbox_in = state_q[63:32];  w_state_sub[63:32]  = w_sbox_out; end
      default: begin w_sbox_in = state_q[31:0]; w_state_sub[31:0]  = w_sbox_out; end
    endcase
  end

  assign w_sbox_last = (cnt_q == 2'd3);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) fsm_q <= S_IDLE;
    else          fsm_q <= fsm_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= '0;
      block_q     <= '0;
      new_block_q <= '0;
      keylen_q    <= 1'b0;
      ready_q     <= 1'b1;
      round_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      new_block_q <= new_block_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      round_q     <= round_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:  if (bus.next) fsm_d = S_INIT;
      S_INIT:  fsm_d = S_SBOX;
      S_SBOX:  if (w_sbox_last) fsm_d = (round_q > 4'd1) ? S_MAIN : S_FINAL;
      S_MAIN:  fsm_d = S_SBOX;
      S_FINAL: fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    new_block_d = new_block_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    round_d     = round_q;
    cnt_d       = cnt_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (bus.next) begin
          block_d  = bus.block;
          keylen_d = bus.keylen;
          ready_d  = 1'b0;
        end
      end
      S_INIT: begin
        state_d = inv_shift_rows(block_q ^ bus.round_key);
        round_d = w_nr;
        cnt_d   = 2'd0;
      end
      S_SBOX: begin
        state_d = w_state_sub;
        if (w_sbox_last) begin
          cnt_d   = 2'd0;
          round_d = round_q - 4'd1;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_MAIN: begin
        state_d = inv_shift_rows(inv_mix_columns(state_q ^ bus.round_key));
      end
      S_FINAL: begin
        new_block_d = state_q ^ bus.round_key;
        ready_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // round_q only becomes Nr after INIT, so INIT presents Nr directly
  assign bus.round     = (fsm_q == S_INIT) ? w_nr : round_q;
  assign bus.new_block = new_block_q;
  assign bus.ready     = ready_q;
endmodule

`default_nettype wire

// File: doc/aes_decipher_block.md
AES_DECIPHER_BLOCK -- requirements
Module: aes_decipher_block

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port next, input, 1 bit: start-decipher request; acted on only in IDLE.
REQ-004 SHALL have port keylen, input, 1 bit: 0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14).
REQ-005 SHALL have port round, output, 4 bits: index of the round key currently required from the external key memory.
REQ-006 SHALL have port round_key, input, 128 bits: key for index round; combinational read; must be valid in the same cycle round is driven.
REQ-007 SHALL have port block, input, 128 bits: ciphertext; byte 0 is [127:120], column-major.
REQ-008 SHALL have port new_block, output, 128 bits: plaintext result register.
REQ-009 SHALL have port ready, output, 1 bit: 1 = idle and new_block valid or reset value; 0 = busy.

Function
REQ-010 SHALL implement FSM states IDLE, INIT, SBOX, MAIN, FINAL.
REQ-011 IDLE with next=1: capture block and keylen into internal registers, clear ready, go to INIT; next=0: stay in IDLE.
REQ-012 INIT (round=Nr): state = captured block XOR round_key, then InvShiftRows; go to SBOX with word counter 0.
REQ-013 SBOX: one internal aes_inv_sbox instance (32-bit word in/out) substitutes state word [counter], one word per cycle, words 0..3; after word 3 go to MAIN if the current round index > 1, else to FINAL; decrement round index on exit.
REQ-014 MAIN (round=r, r=Nr-1..1): state = InvShiftRows(InvMixColumns(state XOR round_key)); go to SBOX.
REQ-015 FINAL (round=0): new_block = state XOR round_key; set ready=1; go to IDLE.
REQ-016 InvMixColumns SHALL use GF(2^8) multiplies by 09, 0b, 0d, 0e with reduction polynomial 0x11b.
REQ-017 Latency: ready SHALL return to 1 exactly 5*Nr+1 rising edges after the edge that samples next (51 for AES-128, 71 for AES-256).
REQ-018 ready SHALL be 0 from the edge after next is sampled until the FINAL edge.
REQ-019 new_block SHALL update only on the FINAL edge and hold its value at all other times, including while busy.
REQ-020 round SHALL be 0 in IDLE and SHALL follow Nr, Nr-1, ..., 1, 0 through INIT/MAIN/FINAL, holding its value during SBOX.
REQ-021 next, block and keylen changes while busy SHALL be ignored; a held next SHALL start a new operation on the first IDLE edge after ready rises.

Reset
REQ-022 reset_n=0 at a rising edge SHALL force IDLE, ready=1, round=0, new_block=128'h0, internal state and word counter cleared.
REQ-023 reset_n=0 mid-operation SHALL abort the operation with no partial update of new_block; next is ignored while reset_n=0.

Configuration
REQ-024 Macro AES_DECIPHER_SBOX_PAR_EN defined: four aes_inv_sbox word instances substitute all 16 bytes in one SBOX cycle; latency becomes 2*Nr+1 (21 / 29).
REQ-025 Macro AES_DECIPHER_SBOX_PAR_EN undefined: a single word-serial instance is used with the 4-cycle SBOX of REQ-013; all other behaviour is identical.

Verification
REQ-026 AES-128: round keys from key 000102030405060708090a0b0c0d0e0f, block=69c4e0d86a7b0430d8cdb78070b4c55a, pulse next -> new_block=00112233445566778899aabbccddeeff, ready high exactly 51 edges later.
REQ-027 AES-256: round keys from key 000102...1e1f, block=8ea2b7ca516745bfeafc49904b496089, keylen=1 -> new_block=00112233445566778899aabbccddeeff after 71 edges; round sequence 14..0 checked.
REQ-028 Busy protection: pulse next again and change block/keylen at edge 20 of an AES-128 operation -> result and latency unchanged from REQ-026.
REQ-029 Reset mid-operation: reset_n=0 for one edge at edge 30 -> ready=1, round=0, new_block=0 on the following cycle; a fresh REQ-026 run then passes.
REQ-030 Back-to-back: next held at 1 across two runs -> second operation starts on the edge after ready rises; the first result stays stable until the second FINAL edge.
REQ-031 With AES_DECIPHER_SBOX_PAR_EN defined, the REQ-026 and REQ-027 vectors -> the same plaintexts with latencies 21 and 29.
